// File: rtl/seg_scan_scheduler.sv
// Frame scheduler for a 4-digit multiplexed 7-segment display: slot sequencing with
// a blank phase per slot, 4-bit PWM brightness, leading-zero suppression, frame-aligned commits.
module seg_scan_scheduler #(
  parameter int SUB_DIV = 3125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_data,
  input  logic [3:0]  i_wr_dp,
  input  logic [3:0]  i_wr_blank,
  output logic        o_wr_ack,
  input  logic [3:0]  i_bright,
  input  logic        i_lz_en,
  output logic [3:0]  o_anode,
  output logic [1:0]  o_seg_sel,
  output logic [3:0]  o_digit_val,
  output logic        o_dp,
  output logic        o_frame_start
);

  localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_DIV - 1);

  logic [SW-1:0] r_sub_cnt;
  logic [3:0]    r_phase;
  logic [1:0]    r_digit;
  logic [15:0]   r_act_data;
  logic [3:0]    r_act_dp;
  logic [3:0]    r_act_blank;
  logic [3:0]    r_bright_q;
  logic          r_wr_ack;
  logic          r_frame_start;
  logic [3:0]    r_anode;
  logic [1:0]    r_seg_sel;
  logic [3:0]    r_digit_val;
  logic          r_dp;

  logic       w_sub_wrap;
  logic       w_slot_end;
  logic       w_frame_wrap;
  logic [3:0] w_supp;
  logic [3:0] w_visible;
  logic       w_cur_vis;
  logic       w_cur_dp;
  logic [3:0] w_cur_nib;
  logic       w_lit;
  logic [3:0] w_anode_nxt;

  assign w_sub_wrap   = (r_sub_cnt == SUB_LAST);
  assign w_slot_end   = w_sub_wrap && (r_phase == 4'd15);
  assign w_frame_wrap = w_slot_end && (r_digit == 2'd3);

  // A digit is suppressed only if it and every digit to its left are zero.
  assign w_supp[3] = i_lz_en && (r_act_data[15:12] == 4'd0);
  assign w_supp[2] = w_supp[3] && (r_act_data[11:8] == 4'd0);
  assign w_supp[1] = w_supp[2] && (r_act_data[7:4] == 4'd0);
  assign w_supp[0] = 1'b0;

  assign w_visible = ~r_act_blank & ~w_supp;
  assign w_cur_vis = w_visible[r_digit];
  assign w_cur_dp  = r_act_dp[r_digit];

  always_comb begin
    w_cur_nib = r_act_data[3:0];
    case (r_digit)
      2'd1:    w_cur_nib = r_act_data[7:4];
      2'd2:    w_cur_nib = r_act_data[11:8];
      2'd3:    w_cur_nib = r_act_data[15:12];
      default: w_cur_nib = r_act_data[3:0];
    endcase
  end

  // Phase 0 is the anti-ghosting blank; phases 1..bright_q drive the anode.
  assign w_lit       = w_cur_vis && (r_phase != 4'd0) && (r_phase <= r_bright_q);
  assign w_anode_nxt = w_lit ? ~(4'b0001 << r_digit) : 4'hF;

  // Handshake: the requester holds i_wr_* stable while i_wr_en is high; contents are
  // captured only on the frame-wrap cycle, acknowledged by a one-cycle o_wr_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sub_cnt     <= '0;
      r_phase       <= 4'd0;
      r_digit       <= 2'd0;
      r_act_data    <= 16'd0;
      r_act_dp      <= 4'd0;
      r_act_blank   <= 4'hF;
      r_bright_q    <= 4'd0;
      r_wr_ack      <= 1'b0;
      r_frame_start <= 1'b0;
      r_anode       <= 4'hF;
      r_seg_sel     <= 2'd0;
      r_digit_val   <= 4'd0;
      r_dp          <= 1'b0;
    end else begin
      if (w_sub_wrap) begin
        r_sub_cnt <= '0;
        r_phase   <= r_phase + 4'd1;
        if (r_phase == 4'd15) r_digit <= r_digit + 2'd1;
      end else begin
        r_sub_cnt <= r_sub_cnt + 1'b1;
      end

      if (w_slot_end) r_bright_q <= i_bright;

      r_frame_start <= w_frame_wrap;
      r_wr_ack      <= 1'b0;
      if (w_frame_wrap) begin
        r_wr_ack <= i_wr_en;
        if (i_wr_en) begin
          r_act_data  <= i_wr_data;
          r_act_dp    <= i_wr_dp;
          r_act_blank <= i_wr_blank;
        end
      end

      r_anode     <= w_anode_nxt;
      r_seg_sel   <= r_digit;
      r_digit_val <= w_cur_nib;
      r_dp        <= w_cur_vis & w_cur_dp;
    end
  end

  assign o_wr_ack      = r_wr_ack;
  assign o_frame_start = r_frame_start;
  assign o_anode       = r_anode;
  assign o_seg_sel     = r_seg_sel;
  assign o_digit_val   = r_digit_val;
  assign o_dp          = r_dp;

endmodule
